// File: rtl/jk_ff_array.sv
// jk_ff_array: WIDTH-bit bank of JK flip-flops sharing one clock. The same bank
// can also work as an up counter, a down counter or a left shift register.
// It has a clock enable, a synchronous parallel load and an asynchronous
// active-low reset.
module jk_ff_array #(
  parameter int unsigned            WIDTH     = 8,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             tc
);

  typedef enum logic [1:0] {
    ModeJk    = 2'b00,
    ModeUp    = 2'b01,
    ModeDown  = 2'b10,
    ModeShift = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_d, q_q;
  logic             tc_d, tc_q;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);

  // Next-state selection: load beats enable, and enable gates the mode operation.
  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (load) begin
      q_d = d;
    end else if (en) begin
      unique case (mode_sel)
        // JK characteristic equation, applied to every bit: q+ = j&~q | ~k&q
        ModeJk:    q_d = (j & ~q_q) | (~k & q_q);
        ModeUp: begin
          q_d  = q_q + 1'b1;
          tc_d = &q_q;
        end
        ModeDown: begin
          q_d  = q_q - 1'b1;
          tc_d = ~|q_q;
        end
        ModeShift: q_d = {q_q[WIDTH-2:0], ser_in};
        default:   q_d = q_q;
      endcase
    end
  end

  // State register. Reset clears it asynchronously to RESET_VAL, with tc low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q  <= RESET_VAL;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign q   = q_q;
  assign q_n = ~q_q;
  assign tc  = tc_q;

endmodule

// File: tb/tb_jk_ff_array.sv
// Scoreboard bench for jk_ff_array with WIDTH=4 and RESET_VAL=1010. The driver
// pushes the expected state into a queue each time it issues stimulus. A
// separate monitor pops the queue and compares after each clock edge, or after
// an asynchronous-reset sample event.
module tb_jk_ff_array;

  localparam int unsigned W  = 4;
  localparam logic [W-1:0] RV = 4'b1010;

  typedef struct {
    string        name;
    logic [W-1:0] q;
    logic         tc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [1:0]   mode;
  logic         load;
  logic [W-1:0] d, j, k;
  logic         ser_in;
  logic [W-1:0] q, q_n;
  logic         tc;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  event sample_ev;

  jk_ff_array #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .load   (load),
    .d      (d),
    .j      (j),
    .k      (k),
    .ser_in (ser_in),
    .q      (q),
    .q_n    (q_n),
    .tc     (tc)
  );

  always #5 clk = ~clk;

  // Monitor: after each edge or async sample request, check the oldest expectation.
  initial begin
    forever begin
      @(posedge clk or sample_ev);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (q !== e.q || q_n !== ~e.q || tc !== e.tc) begin
          errors++;
          $display("FAIL %s: got q=%b q_n=%b tc=%b, expected q=%b q_n=%b tc=%b",
                   e.name, q, q_n, tc, e.q, ~e.q, e.tc);
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input string name, input logic ld, input logic [W-1:0] dv,
                      input logic e, input logic [1:0] m, input logic [W-1:0] jv,
                      input logic [W-1:0] kv, input logic s,
                      input logic [W-1:0] eq, input logic etc);
    exp_t x;
    @(negedge clk);
    #1;
    load = ld; d = dv; en = e; mode = m; j = jv; k = kv; ser_in = s;
    x.name = name; x.q = eq; x.tc = etc;
    exp_q.push_back(x);
  endtask

  // Assert reset between edges and request an immediate sample.
  task automatic async_reset(input string name);
    exp_t x;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    x.name = name; x.q = RV; x.tc = 1'b0;
    exp_q.push_back(x);
    ->sample_ev;
    #2;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    load = 1'b0; en = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0;
    d = '0; j = '0; k = '0; ser_in = 1'b0;
    @(posedge clk);

    async_reset("reset_async");
    release_reset();
    step("reset_hold", 1'b0, 4'b0000, 1'b0, 2'b01, '0, '0, 1'b0, 4'b1010, 1'b0);

    // JK: bit3 toggle, bit2 set, bit1 reset, bit0 hold
    step("load_0",  1'b1, 4'b0000, 1'b0, 2'b00, '0, '0, 1'b0, 4'b0000, 1'b0);
    step("jk_1",    1'b0, 4'b0000, 1'b1, 2'b00, 4'b1100, 4'b1010, 1'b1, 4'b1100, 1'b0);
    step("jk_2",    1'b0, 4'b0000, 1'b1, 2'b00, 4'b1100, 4'b1010, 1'b1, 4'b0100, 1'b0);

    // Up count through the wrap; j/k are driven to show they are ignored
    step("load_e",  1'b1, 4'b1110, 1'b1, 2'b11, '0, '0, 1'b1, 4'b1110, 1'b0);
    step("up_1",    1'b0, 4'b0000, 1'b1, 2'b01, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b0);
    step("up_wrap", 1'b0, 4'b0000, 1'b1, 2'b01, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b1);
    step("up_3",    1'b0, 4'b0000, 1'b1, 2'b01, '0, '0, 1'b0, 4'b0001, 1'b0);

    // Down count with enable gating
    step("load_1",  1'b1, 4'b0001, 1'b0, 2'b10, '0, '0, 1'b0, 4'b0001, 1'b0);
    step("dn_1",    1'b0, 4'b0000, 1'b1, 2'b10, '0, '0, 1'b0, 4'b0000, 1'b0);
    step("dn_gate", 1'b0, 4'b0000, 1'b0, 2'b10, '0, '0, 1'b0, 4'b0000, 1'b0);
    step("dn_wrap", 1'b0, 4'b0000, 1'b1, 2'b10, '0, '0, 1'b0, 4'b1111, 1'b1);
    step("dn_tc1",  1'b0, 4'b0000, 1'b0, 2'b10, '0, '0, 1'b0, 4'b1111, 1'b0);

    // Shift left, then load overriding a disabled cycle
    step("load_0b", 1'b1, 4'b0000, 1'b0, 2'b11, '0, '0, 1'b0, 4'b0000, 1'b0);
    step("sh_1",    1'b0, 4'b0000, 1'b1, 2'b11, 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0);
    step("sh_2",    1'b0, 4'b0000, 1'b1, 2'b11, '0, '0, 1'b1, 4'b0011, 1'b0);
    step("sh_3",    1'b0, 4'b0000, 1'b1, 2'b11, '0, '0, 1'b0, 4'b0110, 1'b0);
    step("sh_4",    1'b0, 4'b0000, 1'b1, 2'b11, '0, '0, 1'b1, 4'b1101, 1'b0);
    step("ld_pri",  1'b1, 4'b0101, 1'b0, 2'b11, '0, '0, 1'b1, 4'b0101, 1'b0);

    // Load beats a pending wrap, then count, then reset mid-count
    step("load_f",  1'b1, 4'b1111, 1'b0, 2'b01, '0, '0, 1'b0, 4'b1111, 1'b0);
    step("ld_wrap", 1'b1, 4'b0011, 1'b1, 2'b01, '0, '0, 1'b0, 4'b0011, 1'b0);
    step("up_4",    1'b0, 4'b0000, 1'b1, 2'b01, '0, '0, 1'b0, 4'b0100, 1'b0);
    async_reset("reset_mid");
    release_reset();
    step("up_rv",   1'b0, 4'b0000, 1'b1, 2'b01, '0, '0, 1'b0, 4'b1011, 1'b0);
    step("hold",    1'b0, 4'b0000, 1'b0, 2'b01, '0, '0, 1'b0, 4'b1011, 1'b0);

    // Let the monitor drain the queue, within a bounded number of cycles
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
